filtro_promedio_9: RTL and testbench

Averaging stage of the input filter peripheral. Accepts a stream of samples over a valid/ready handshake and accumulates blocks of exactly 9. For each block it computes the rounded mean with a sequential shift-subtract divider, then holds the result on a valid/ack output until the bus-side register interface takes it. It sits downstream of the sampling logic and upstream of the peripheral's readable result register.

---
 rtl/filtro_pkg.sv | 14 +
 rtl/divisor_const_9.sv | 57 +++++
 rtl/filtro_promedio_9.sv | 100 ++++++++++
 tb/tb_filtro_promedio_9.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared types and constants for the 9-sample averaging stage.
package filtro_pkg;

  typedef enum logic [1:0] {
    ACUMULA,
    DIVIDE,
    ENTREGA
  } estado_prom_t;

  localparam int N_MUESTRAS = 9;
  localparam int BIAS_RED   = 4;
  localparam int ITER_DIV   = 16;

endpackage

// File: rtl/divisor_const_9.sv
// Sequential restoring divider by 9, MSB first, one quotient bit per clock.
// listo/cociente present the 16th iteration combinationally so the caller can latch it on that edge.
module divisor_const_9
  import filtro_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cargar,
  input  logic [15:0] dividendo,
  output logic        listo,
  output logic [15:0] cociente
);

  logic [4:0]  resto;
  logic [15:0] desplaza;
  logic [3:0]  cuenta;
  logic        activo;

  logic [5:0]  tanteo;
  logic [4:0]  resto_sig;
  logic        bit_q;

  always_comb begin
    tanteo = {resto, desplaza[15]};
    if (tanteo >= 6'(N_MUESTRAS)) begin
      bit_q     = 1'b1;
      resto_sig = 5'(tanteo - 6'(N_MUESTRAS));
    end else begin
      bit_q     = 1'b0;
      resto_sig = tanteo[4:0];
    end
  end

  // dividend bits shift out the top while quotient bits shift in at the bottom
  assign cociente = {desplaza[14:0], bit_q};
  assign listo    = activo && (cuenta == 4'(ITER_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resto    <= '0;
      desplaza <= '0;
      cuenta   <= '0;
      activo   <= 1'b0;
    end else if (cargar) begin
      resto    <= '0;
      desplaza <= dividendo;
      cuenta   <= '0;
      activo   <= 1'b1;
    end else if (activo) begin
      resto    <= resto_sig;
      desplaza <= cociente;
      cuenta   <= cuenta + 4'd1;
      if (listo) activo <= 1'b0;
    end
  end

endmodule

// File: rtl/filtro_promedio_9.sv
// Accumulates blocks of 9 samples and delivers the rounded mean over a valid/ack port.
//   state   | meaning
//   ACUMULA | accepting samples, summing into acc
//   DIVIDE  | divider running on (sum + 4)
//   ENTREGA | result held until promedio_tomado
module filtro_promedio_9
  import filtro_pkg::*;
#(
  parameter int ANCHO = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             limpiar,
  input  logic             muestra_valida,
  input  logic [ANCHO-1:0] muestra,
  output logic             muestra_lista,
  output logic [3:0]       indice,
  output logic [ANCHO-1:0] promedio,
  output logic             promedio_valido,
  input  logic             promedio_tomado,
  output logic             ocupado
);

  estado_prom_t      estado;
  logic [ANCHO+3:0]  acc;
  logic [15:0]       suma_sesgada;
  logic              acepta;
  logic              cierra_bloque;
  logic              div_listo;
  logic [15:0]       div_cociente;

  assign acepta        = (estado == ACUMULA) && muestra_valida && !limpiar;
  assign cierra_bloque = acepta && (indice == 4'(N_MUESTRAS - 1));
  assign suma_sesgada  = 16'(acc) + 16'(muestra) + 16'(BIAS_RED);

  divisor_const_9 u_divisor (
    .clk       (clk),
    .rst       (rst),
    .cargar    (cierra_bloque),
    .dividendo (suma_sesgada),
    .listo     (div_listo),
    .cociente  (div_cociente)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado          <= ACUMULA;
      acc             <= '0;
      indice          <= '0;
      promedio        <= '0;
      promedio_valido <= 1'b0;
      muestra_lista   <= 1'b1;
      ocupado         <= 1'b0;
    end else if (limpiar) begin
      // a divider run left behind is ignored: listo only matters in DIVIDE
      estado          <= ACUMULA;
      acc             <= '0;
      indice          <= '0;
      promedio_valido <= 1'b0;
      muestra_lista   <= 1'b1;
      ocupado         <= 1'b0;
    end else begin
      case (estado)
        ACUMULA: begin
          if (cierra_bloque) begin
            estado        <= DIVIDE;
            acc           <= '0;
            indice        <= '0;
            muestra_lista <= 1'b0;
            ocupado       <= 1'b1;
          end else if (acepta) begin
            acc    <= acc + (ANCHO+4)'(muestra);
            indice <= indice + 4'd1;
          end
        end
        DIVIDE: begin
          if (div_listo) begin
            promedio        <= ANCHO'(div_cociente);
            promedio_valido <= 1'b1;
            ocupado         <= 1'b0;
            estado          <= ENTREGA;
          end
        end
        ENTREGA: begin
          if (promedio_tomado) begin
            promedio_valido <= 1'b0;
            muestra_lista   <= 1'b1;
            estado          <= ACUMULA;
          end
        end
        default: begin
          estado        <= ACUMULA;
          muestra_lista <= 1'b1;
          ocupado       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_promedio_9.sv
// Bench for filtro_promedio_9: block stimulus against an arithmetic mean model.
module tb_filtro_promedio_9;

  localparam int ANCHO = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic             limpiar;
  logic             muestra_valida;
  logic [ANCHO-1:0] muestra;
  logic             muestra_lista;
  logic [3:0]       indice;
  logic [ANCHO-1:0] promedio;
  logic             promedio_valido;
  logic             promedio_tomado;
  logic             ocupado;

  filtro_promedio_9 #(.ANCHO(ANCHO)) dut (
    .clk             (clk),
    .rst             (rst),
    .limpiar         (limpiar),
    .muestra_valida  (muestra_valida),
    .muestra         (muestra),
    .muestra_lista   (muestra_lista),
    .indice          (indice),
    .promedio        (promedio),
    .promedio_valido (promedio_valido),
    .promedio_tomado (promedio_tomado),
    .ocupado         (ocupado)
  );

  always #5 clk = ~clk;

  int          n_pruebas = 0;
  int          n_fallos  = 0;
  int unsigned blk [9];
  logic [31:0] prom_ref = 0;
  logic [31:0] prom_pend;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_pruebas++;
    if (obs !== exp) begin
      n_fallos++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic flanco();
    @(posedge clk);
    #1;
  endtask

  // Feeds blk[0..8]; expected mean is floor((sum+4)/9). With esperar, follows the block to ENTREGA.
  task automatic bloque(input bit huecos, input bit esperar);
    int unsigned suma = 0;
    for (int i = 0; i < 9; i++) begin
      if (huecos) begin
        int g = int'($urandom_range(0, 2));
        for (int j = 0; j < g; j++) begin
          @(negedge clk);
          muestra_valida  = 1'b0;
          promedio_tomado = 1'b0;
          muestra         = ANCHO'($urandom);
          flanco();
          check_val("indice_hueco", 32'(indice), 32'(i));
        end
      end
      @(negedge clk);
      promedio_tomado = 1'b0;
      muestra_valida  = 1'b1;
      muestra         = ANCHO'(blk[i]);
      suma += blk[i];
      flanco();
      check_val("indice", 32'(indice), (i == 8) ? 32'd0 : 32'(i + 1));
      if (i < 8) check_val("lista_acumula", 32'(muestra_lista), 32'd1);
    end
    @(negedge clk);
    muestra_valida = 1'b0;
    check_val("lista_divide", 32'(muestra_lista), 32'd0);
    check_val("ocupado_k", 32'(ocupado), 32'd1);
    prom_pend = 32'((suma + 4) / 9);
    if (esperar) begin
      for (int c = 1; c < 16; c++) begin
        flanco();
        check_val("valido_prematuro", 32'(promedio_valido), 32'd0);
        check_val("ocupado_divide", 32'(ocupado), 32'd1);
      end
      flanco();
      check_val("valido_k16", 32'(promedio_valido), 32'd1);
      check_val("promedio", 32'(promedio), prom_pend);
      check_val("ocupado_fin", 32'(ocupado), 32'd0);
      check_val("lista_entrega", 32'(muestra_lista), 32'd0);
      prom_ref = prom_pend;
    end
  endtask

  task automatic tomar();
    @(negedge clk);
    promedio_tomado = 1'b1;
    flanco();
    check_val("valido_tras_ack", 32'(promedio_valido), 32'd0);
    check_val("lista_tras_ack", 32'(muestra_lista), 32'd1);
    check_val("promedio_tras_ack", 32'(promedio), prom_ref);
  endtask

  task automatic llenar(input int unsigned v);
    for (int i = 0; i < 9; i++) blk[i] = v;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_lista"}, 32'(muestra_lista), 32'd1);
    check_val({tag, "_indice"}, 32'(indice), 32'd0);
    check_val({tag, "_promedio"}, 32'(promedio), 32'd0);
    check_val({tag, "_valido"}, 32'(promedio_valido), 32'd0);
    check_val({tag, "_ocupado"}, 32'(ocupado), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    limpiar         = 1'b0;
    muestra_valida  = 1'b0;
    muestra         = '0;
    promedio_tomado = 1'b0;
    repeat (3) flanco();
    check_reset("reset");
    @(negedge clk);
    rst = 1'b1;

    // nine 100s, back to back
    llenar(100);
    bloque(1'b0, 1'b1);
    check_val("media_100", prom_ref, 32'd100);
    tomar();

    // 0..8 with gaps
    for (int i = 0; i < 9; i++) blk[i] = i;
    bloque(1'b1, 1'b1);
    tomar();

    // rounding boundaries
    llenar(1); blk[8] = 5;
    bloque(1'b0, 1'b1);
    tomar();
    llenar(1); blk[8] = 6;
    bloque(1'b0, 1'b1);
    tomar();
    llenar(4095);
    bloque(1'b0, 1'b1);
    tomar();

    // backpressure: result held 20 cycles, offered samples ignored
    for (int i = 0; i < 9; i++) blk[i] = $urandom_range(0, 4095);
    bloque(1'b0, 1'b1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      muestra_valida  = 1'b1;
      muestra         = ANCHO'($urandom);
      promedio_tomado = 1'b0;
      flanco();
      check_val("bp_promedio", 32'(promedio), prom_ref);
      check_val("bp_valido", 32'(promedio_valido), 32'd1);
      check_val("bp_lista", 32'(muestra_lista), 32'd0);
      check_val("bp_indice", 32'(indice), 32'd0);
    end
    @(negedge clk);
    muestra_valida = 1'b0;
    tomar();
    for (int i = 0; i < 9; i++) blk[i] = $urandom_range(0, 4095);
    bloque(1'b0, 1'b1);
    tomar();

    // async reset in the 8th DIVIDE cycle
    llenar(3000);
    bloque(1'b0, 1'b0);
    repeat (7) flanco();
    #2;
    rst = 1'b0;
    #1;
    check_reset("reset_divide");
    prom_ref = 0;
    @(negedge clk);
    rst = 1'b1;
    llenar(7);
    bloque(1'b0, 1'b1);
    tomar();

    // limpiar after 5 accepts, with a sample offered on the same edge
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      promedio_tomado = 1'b0;
      muestra_valida  = 1'b1;
      muestra         = ANCHO'($urandom_range(1000, 4095));
      flanco();
    end
    check_val("indice_5", 32'(indice), 32'd5);
    @(negedge clk);
    limpiar = 1'b1;
    muestra = 12'd4000;
    flanco();
    check_val("limpiar_indice", 32'(indice), 32'd0);
    check_val("limpiar_lista", 32'(muestra_lista), 32'd1);
    check_val("limpiar_promedio", 32'(promedio), prom_ref);
    @(negedge clk);
    limpiar        = 1'b0;
    muestra_valida = 1'b0;
    llenar(50);
    bloque(1'b0, 1'b1);

    // limpiar together with the ack in ENTREGA
    @(negedge clk);
    limpiar         = 1'b1;
    promedio_tomado = 1'b1;
    flanco();
    check_val("limpiar_ack_valido", 32'(promedio_valido), 32'd0);
    check_val("limpiar_ack_lista", 32'(muestra_lista), 32'd1);
    check_val("limpiar_ack_promedio", 32'(promedio), prom_ref);
    @(negedge clk);
    limpiar         = 1'b0;
    promedio_tomado = 1'b0;

    // limpiar mid-DIVIDE: no result, next block clean
    llenar(2000);
    bloque(1'b0, 1'b0);
    repeat (3) flanco();
    @(negedge clk);
    limpiar = 1'b1;
    flanco();
    check_val("limpiar_div_ocupado", 32'(ocupado), 32'd0);
    check_val("limpiar_div_lista", 32'(muestra_lista), 32'd1);
    @(negedge clk);
    limpiar = 1'b0;
    repeat (20) begin
      flanco();
      check_val("limpiar_div_sin_valido", 32'(promedio_valido), 32'd0);
    end
    for (int i = 0; i < 9; i++) blk[i] = $urandom_range(0, 4095);
    bloque(1'b0, 1'b1);
    tomar();

    // random blocks with random gaps
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 9; i++) blk[i] = $urandom_range(0, 4095);
      bloque(1'b1, 1'b1);
      tomar();
    end

    $display("[TB] %0d tests run, %0d failed", n_pruebas, n_fallos);
    $finish;
  end

endmodule
